dmem_bus_bridge: RTL and testbench

- Sits directly downstream of the single-cycle core's data-memory port (dmem_addr/dmem_write_data/dmem_byte_enable/dmem_read/dmem_write/dmem_read_data).
- Converts each combinational core access into a valid/ready request plus a later response on a multi-cycle system bus.
- Drives a stall back to the core that freezes the PC and register-file write enable until the access completes.
- Adds a response timeout that returns a fault instead of hanging the core.

---
 rtl/dmem_bus_bridge.sv | 118 +++++++++++
 tb/tb_dmem_bus_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - bridges the core's combinational data-memory port onto a valid/ready request/response bus
// Stalls the core for the length of each access; a response timeout completes the access with a fault.
module dmem_bus_bridge #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] FAULT_RDATA    = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_be,
    input  logic        core_read,
    input  logic        core_write,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        core_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        bus_we,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_data,
    input  logic        bus_resp_err
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          r_we;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rdata;
    logic          r_fault;
    logic          w_access;
    logic          w_timeout;

    assign w_access  = core_read | core_write;
    assign w_timeout = (r_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_access) w_next = S_REQ;
            S_REQ:   if (bus_req_ready) w_next = S_WAIT;
            S_WAIT:  if (bus_resp_valid || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Responses arriving outside WAIT (e.g. for a request abandoned by reset) are dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_addr  <= core_addr;
                        r_wdata <= core_wdata;
                        r_be    <= core_be;
                        r_we    <= core_write;
                    end
                end
                S_REQ: begin
                    if (bus_req_ready) r_cnt <= '0;
                end
                S_WAIT: begin
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                    if (bus_resp_valid) begin
                        r_fault <= bus_resp_err;
                        if (bus_resp_err) begin
                            r_rdata <= FAULT_RDATA;
                        end else if (!r_we) begin
                            r_rdata <= bus_resp_data;
                        end
                    end else if (w_timeout) begin
                        r_rdata <= FAULT_RDATA;
                        r_fault <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_stall    = w_access & (r_state != S_DONE);
    assign core_fault    = (r_state == S_DONE) & r_fault;
    assign core_rdata    = r_rdata;
    assign bus_req_valid = (r_state == S_REQ);
    assign bus_addr      = r_addr;
    assign bus_wdata     = r_wdata;
    assign bus_be        = r_be;
    assign bus_we        = r_we;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb/tb_dmem_bus_bridge.sv - self-checking bench for dmem_bus_bridge
module tb_dmem_bus_bridge;

    localparam int          TO    = 8;
    localparam logic [31:0] FAULT = 32'hBAD0_BAD0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic [3:0]  core_be = '0;
    logic        core_read = 1'b0;
    logic        core_write = 1'b0;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        core_fault;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we;
    logic        bus_resp_valid = 1'b0;
    logic [31:0] bus_resp_data = '0;
    logic        bus_resp_err = 1'b0;

    dmem_bus_bridge #(.TIMEOUT_CYCLES(TO), .FAULT_RDATA(FAULT)) dut (
        .clock(clock), .reset_n(reset_n),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_be(core_be),
        .core_read(core_read), .core_write(core_write),
        .core_rdata(core_rdata), .core_stall(core_stall), .core_fault(core_fault),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_we(bus_we),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data), .bus_resp_err(bus_resp_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        bit          both;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          rdy;
        int          rsp;
        bit          err;
        logic [31:0] data;
        int          e_stall;
        logic [31:0] e_rdata;
        bit          e_fault;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] last_rdata = '0;
    vec_t        tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic vec_t mk(bit wr, bit both, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be,
                                int rdy, int rsp, bit err, logic [31:0] data,
                                int e_stall, logic [31:0] e_rdata, bit e_fault);
        vec_t v;
        v.wr = wr; v.both = both; v.addr = addr; v.wdata = wdata; v.be = be;
        v.rdy = rdy; v.rsp = rsp; v.err = err; v.data = data;
        v.e_stall = e_stall; v.e_rdata = e_rdata; v.e_fault = e_fault;
        return v;
    endfunction

    // Reference: cost = detect + request cycles + wait cycles (capped by the timeout).
    function automatic vec_t model(vec_t v, logic [31:0] prev);
        vec_t r = v;
        bit   answered = (v.rsp < TO);
        r.e_stall = 1 + (v.rdy + 1) + (answered ? v.rsp + 1 : TO);
        if (!answered)   begin r.e_rdata = FAULT; r.e_fault = 1'b1; end
        else if (v.err)  begin r.e_rdata = FAULT; r.e_fault = 1'b1; end
        else             begin r.e_rdata = v.wr ? prev : v.data; r.e_fault = 1'b0; end
        return r;
    endfunction

    // Entered just after a rising edge; returns just after the rising edge that ends DONE.
    task automatic run_access(input vec_t v, input string tag);
        int stall_cnt = 0, cyc = 0, rdy_wait = 0, wait_cnt = 0;
        int dup = 0, field_err = 0, bad_fault = 0, bad_rdata = 0;
        bit accepted = 0, responded = 0, done = 0;
        logic [68:0] exp_fields;
        core_addr  = v.addr;
        core_wdata = v.wdata;
        core_be    = v.be;
        core_write = v.wr;
        core_read  = !v.wr || v.both;
        exp_fields = {v.addr, v.wdata, v.be, v.wr};
        while (!done && cyc < 300) begin
            @(negedge clock);
            cyc++;
            bus_req_ready  = 1'b0;
            bus_resp_valid = 1'b0;
            bus_resp_err   = 1'b0;
            if (!core_stall) begin
                done = 1;
            end else begin
                stall_cnt++;
                if (core_fault) bad_fault++;
                if (core_rdata !== last_rdata) bad_rdata++;
                if (bus_req_valid) begin
                    if (accepted) dup++;
                    else begin
                        if ({bus_addr, bus_wdata, bus_be, bus_we} !== exp_fields) field_err++;
                        if (rdy_wait == v.rdy) begin bus_req_ready = 1'b1; accepted = 1; end
                        else rdy_wait++;
                    end
                end else if (accepted && !responded) begin
                    if (wait_cnt == v.rsp) begin
                        bus_resp_valid = 1'b1;
                        bus_resp_data  = v.data;
                        bus_resp_err   = v.err;
                        responded      = 1;
                    end
                    wait_cnt++;
                end
            end
        end
        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(v.e_stall));
        chk({tag, " core_rdata"}, core_rdata, v.e_rdata);
        chk({tag, " core_fault"}, 32'(core_fault), 32'(v.e_fault));
        chk({tag, " req_accepted_once"}, 32'(accepted), 32'd1);
        chk({tag, " req_duplicates"}, 32'(dup), 32'd0);
        chk({tag, " req_fields"}, 32'(field_err), 32'd0);
        chk({tag, " fault_outside_done"}, 32'(bad_fault), 32'd0);
        chk({tag, " rdata_changed_early"}, 32'(bad_rdata), 32'd0);
        last_rdata = v.e_rdata;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        core_read  = 1'b0;
        core_write = 1'b0;
        repeat (n) begin
            @(negedge clock);
            chk("idle stall", 32'(core_stall), 32'd0);
            chk("idle fault", 32'(core_fault), 32'd0);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t v;
        tbl[0] = mk(0, 0, 32'h100, 32'h0,         4'hF, 0, 0,  0, 32'hCAFE_F00D, 3,  32'hCAFE_F00D, 0);
        tbl[1] = mk(1, 0, 32'h204, 32'hAB00_0000, 4'hC, 3, 0,  0, 32'h1234_5678, 6,  32'hCAFE_F00D, 0);
        tbl[2] = mk(0, 0, 32'h300, 32'h0,         4'hF, 0, 99, 0, 32'h0,         10, FAULT,         1);
        tbl[3] = mk(0, 0, 32'h304, 32'h0,         4'hF, 1, 2,  1, 32'h5555_5555, 6,  FAULT,         1);
        tbl[4] = mk(0, 0, 32'h308, 32'h0,         4'hF, 0, 1,  0, 32'h1357_9BDF, 4,  32'h1357_9BDF, 0);
        tbl[5] = mk(0, 0, 32'h30C, 32'h0,         4'hF, 0, 7,  0, 32'h2468_ACE0, 10, 32'h2468_ACE0, 0);
        tbl[6] = mk(1, 0, 32'h400, 32'hFFFF_0000, 4'hF, 2, 0,  1, 32'h0,         5,  FAULT,         1);
        tbl[7] = mk(1, 0, 32'h404, 32'h0000_00EE, 4'h1, 0, 0,  0, 32'h7777_7777, 3,  FAULT,         0);
        tbl[8] = mk(1, 1, 32'h40C, 32'h0102_0304, 4'h3, 0, 0,  0, 32'h8888_8888, 3,  FAULT,         0);

        repeat (3) @(negedge clock);
        chk("reset core_rdata", core_rdata, 32'h0);
        chk("reset core_fault", 32'(core_fault), 32'd0);
        chk("reset core_stall", 32'(core_stall), 32'd0);
        chk("reset bus_req_valid", 32'(bus_req_valid), 32'd0);
        chk("reset bus_fields", {bus_addr[15:0], bus_wdata[7:0], bus_be, 3'b0, bus_we}, 32'h0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Table vectors run back to back: the core keeps its request asserted across DONE.
        for (int i = 0; i < 9; i++) run_access(tbl[i], $sformatf("vec%0d", i));
        idle(2);

        // Reset in the middle of WAIT, followed by the abandoned request's late response.
        core_addr = 32'h500; core_read = 1'b1; core_write = 1'b0; core_be = 4'hF;
        @(negedge clock);
        @(negedge clock);
        chk("rst_seq req_valid", 32'(bus_req_valid), 32'd1);
        bus_req_ready = 1'b1;
        @(negedge clock);
        bus_req_ready = 1'b0;
        reset_n   = 1'b0;
        core_read = 1'b0;
        #1;
        chk("rst_seq stall", 32'(core_stall), 32'd0);
        chk("rst_seq req_valid_low", 32'(bus_req_valid), 32'd0);
        chk("rst_seq bus_addr", bus_addr, 32'h0);
        chk("rst_seq core_rdata", core_rdata, 32'h0);
        @(negedge clock);
        reset_n        = 1'b1;
        bus_resp_valid = 1'b1;
        bus_resp_data  = 32'hFFFF_FFFF;
        @(negedge clock);
        bus_resp_valid = 1'b0;
        chk("rst_seq late_resp rdata", core_rdata, 32'h0);
        chk("rst_seq late_resp fault", 32'(core_fault), 32'd0);
        chk("rst_seq late_resp stall", 32'(core_stall), 32'd0);
        chk("rst_seq late_resp req", 32'(bus_req_valid), 32'd0);
        last_rdata = 32'h0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 40; i++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.both  = v.wr && ($urandom_range(0, 3) == 0);
            v.addr  = $urandom & 32'hFFFF_FFFC;
            v.wdata = $urandom;
            v.be    = 4'($urandom_range(1, 15));
            v.rdy   = $urandom_range(0, 3);
            v.rsp   = $urandom_range(0, 10);
            v.err   = ($urandom_range(0, 3) == 0);
            v.data  = $urandom;
            v       = model(v, last_rdata);
            run_access(v, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
